// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the A-matrix sequencer state encoding and the
// entry-offset helper used when addressing polynomials in coefficient RAM.
package kyber_pkg;

   localparam int KYBER_Q  = 3329;
   localparam int COEFF_W  = 12;
   localparam int RAM_AW   = 10;
   localparam int RAM_DW   = 96;
   localparam int SEED_W   = 256;
   localparam int XOF_IN_W = 272;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_GRST = 3'd1,
      ST_ARM  = 3'd2,
      ST_WAIT = 3'd3,
      ST_NEXT = 3'd4,
      ST_DONE = 3'd5
   } seq_state_e;

   // Word address of matrix entry number idx; the sum wraps silently.
   function automatic logic [RAM_AW-1:0] entry_offset(
      input logic [RAM_AW-1:0] base,
      input logic [3:0]        idx,
      input int                words_per_poly
   );
      return base + RAM_AW'(int'(idx) * words_per_poly);
   endfunction

endpackage

// File: rtl/a_seed_builder.sv
// Combinational mapping from a matrix index (i, j) to the 272-bit XOF seed
// and the RAM word offset where that polynomial lands.
module a_seed_builder
   import kyber_pkg::*;
#(
   parameter int K              = 3,
   parameter int WORDS_PER_POLY = 32
) (
   input  logic [SEED_W-1:0]   rho,
   input  logic [1:0]          i,
   input  logic [1:0]          j,
   input  logic                transpose,
   input  logic [RAM_AW-1:0]   ram_base,
   output logic [0:XOF_IN_W-1] gen_m,
   output logic [RAM_AW-1:0]   gen_ram_offset
);

   logic [7:0] byte_a;
   logic [7:0] byte_b;
   logic [3:0] idx;

   always_comb begin
      // Non-transposed seeds put the column index first.
      byte_a         = {6'd0, (transpose ? i : j)};
      byte_b         = {6'd0, (transpose ? j : i)};
      gen_m          = {rho, byte_a, byte_b};
      idx            = 4'(int'(i) * K + int'(j));
      gen_ram_offset = entry_offset(ram_base, idx, WORDS_PER_POLY);
   end

endmodule

// File: rtl/a_matrix_sequencer.sv
// Walks the K x K entries of matrix A row-major, handing each seed and RAM
// offset to the A-generator and waiting (with timeout) for its finish flag.
module a_matrix_sequencer
   import kyber_pkg::*;
#(
   parameter int K              = 3,
   parameter int WORDS_PER_POLY = 32,
   parameter int TIMEOUT        = 1023,
   parameter int TW             = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                transpose,
   input  logic [255:0]        rho,
   input  logic [9:0]          ram_base,
   output logic [0:271]        gen_M,
   output logic [9:0]          gen_ram_offset,
   output logic                gen_rst,
   output logic                gen_active,
   input  logic                gen_done,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          row,
   output logic [1:0]          col
);

   generate
      if (K < 2 || K > 4) begin : g_bad_k
         $error("a_matrix_sequencer: K must be 2, 3 or 4");
      end
      if ((2 ** TW) <= TIMEOUT) begin : g_bad_tw
         $error("a_matrix_sequencer: TW too narrow for TIMEOUT");
      end
   endgenerate

   seq_state_e          state_q, state_d;
   logic [1:0]          i_q, i_d;
   logic [1:0]          j_q, j_d;
   logic [SEED_W-1:0]   rho_q, rho_d;
   logic                tr_q, tr_d;
   logic [RAM_AW-1:0]   base_q, base_d;
   logic [TW-1:0]       cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [0:XOF_IN_W-1] gen_m_q, gen_m_d;
   logic [RAM_AW-1:0]   off_q, off_d;

   // Fed from next-state values so the registered seed is valid on entry to GRST.
   a_seed_builder #(
      .K              (K),
      .WORDS_PER_POLY (WORDS_PER_POLY)
   ) u_seed_builder (
      .rho            (rho_d),
      .i              (i_d),
      .j              (j_d),
      .transpose      (tr_d),
      .ram_base       (base_d),
      .gen_m          (gen_m_d),
      .gen_ram_offset (off_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         rho_q   <= '0;
         tr_q    <= 1'b0;
         base_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         gen_m_q <= '0;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         rho_q   <= rho_d;
         tr_q    <= tr_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         gen_m_q <= gen_m_d;
         off_q   <= off_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      rho_d   = rho_q;
      tr_d    = tr_q;
      base_d  = base_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               rho_d   = rho;
               tr_d    = transpose;
               base_d  = ram_base;
               i_d     = '0;
               j_d     = '0;
               err_d   = 1'b0;
               state_d = ST_GRST;
            end
         end
         ST_GRST: state_d = ST_ARM;
         ST_ARM: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + TW'(1);
            // A finish flag arriving on the timeout cycle still counts as success.
            if (gen_done) begin
               state_d = ST_NEXT;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_NEXT: begin
            if (j_q < 2'(K - 1)) begin
               j_d     = j_q + 2'd1;
               state_d = ST_GRST;
            end else if (i_q < 2'(K - 1)) begin
               i_d     = i_q + 2'd1;
               j_d     = '0;
               state_d = ST_GRST;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      // The generator is held in reset for as long as the sequencer is.
      gen_rst        = rst | (state_q == ST_GRST);
      gen_active     = (state_q == ST_ARM) | (state_q == ST_WAIT);
      busy           = (state_q != ST_IDLE);
      done           = (state_q == ST_DONE);
      err            = err_q;
      row            = i_q;
      col            = j_q;
      gen_M          = gen_m_q;
      gen_ram_offset = off_q;
   end

endmodule

// File: tb/tb_a_matrix_sequencer.sv
// Randomized self-checking bench: a K=3 (short timeout) and a K=2 sequencer,
// each driven by a stub generator, checked against an index-walk model.
module tb_a_matrix_sequencer;

   localparam int TO3 = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, start, transpose, sel;
   logic [255:0] rho;
   logic [9:0]   ram_base;
   int           stub_lat;
   logic         stub_stall;
   int           n_vec = 0;
   int           n_err = 0;

   logic         start3, start2;
   logic [0:271] g3_m, g2_m;
   logic [9:0]   g3_off, g2_off;
   logic         g3_rst, g3_act, g3_busy, g3_done, g3_err, gdone3;
   logic         g2_rst, g2_act, g2_busy, g2_done, g2_err, gdone2;
   logic [1:0]   g3_row, g3_col, g2_row, g2_col;

   assign start3 = start & ~sel;
   assign start2 = start & sel;

   a_matrix_sequencer #(.K(3), .WORDS_PER_POLY(32), .TIMEOUT(TO3), .TW(5)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .transpose(transpose), .rho(rho),
      .ram_base(ram_base), .gen_M(g3_m), .gen_ram_offset(g3_off), .gen_rst(g3_rst),
      .gen_active(g3_act), .gen_done(gdone3), .busy(g3_busy), .done(g3_done),
      .err(g3_err), .row(g3_row), .col(g3_col));

   a_matrix_sequencer #(.K(2), .WORDS_PER_POLY(32), .TIMEOUT(1023), .TW(10)) u_dut2 (
      .clk(clk), .rst(rst), .start(start2), .transpose(transpose), .rho(rho),
      .ram_base(ram_base), .gen_M(g2_m), .gen_ram_offset(g2_off), .gen_rst(g2_rst),
      .gen_active(g2_act), .gen_done(gdone2), .busy(g2_busy), .done(g2_done),
      .err(g2_err), .row(g2_row), .col(g2_col));

   // Stub generators: finish stub_lat cycles after enable, unless stalled.
   int cnt3, cnt2;
   always @(posedge clk) begin
      if (g3_rst) cnt3 <= 0; else if (g3_act) cnt3 <= cnt3 + 1;
      if (g2_rst) cnt2 <= 0; else if (g2_act) cnt2 <= cnt2 + 1;
   end
   assign gdone3 = g3_act && !stub_stall && (cnt3 >= stub_lat);
   assign gdone2 = g2_act && !stub_stall && (cnt2 >= stub_lat);

   logic [0:271] o_m;
   logic [9:0]   o_off;
   logic         o_rst, o_act, o_busy, o_done, o_err;
   logic [1:0]   o_row, o_col;
   assign o_m    = sel ? g2_m    : g3_m;
   assign o_off  = sel ? g2_off  : g3_off;
   assign o_rst  = sel ? g2_rst  : g3_rst;
   assign o_act  = sel ? g2_act  : g3_act;
   assign o_busy = sel ? g2_busy : g3_busy;
   assign o_done = sel ? g2_done : g3_done;
   assign o_err  = sel ? g2_err  : g3_err;
   assign o_row  = sel ? g2_row  : g3_row;
   assign o_col  = sel ? g2_col  : g3_col;

   task automatic chk(input string tag, input logic [271:0] obs, input logic [271:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [271:0] model_seed(input logic [255:0] r, input logic tr,
                                               input int i, input int j);
      logic [7:0] first_b, second_b;
      first_b  = tr ? 8'(i) : 8'(j);
      second_b = tr ? 8'(j) : 8'(i);
      return {r, first_b, second_b};
   endfunction

   function automatic logic [9:0] model_off(input logic [9:0] base, input int kk,
                                            input int i, input int j);
      return 10'((int'(base) + (i * kk + j) * 32) % 1024);
   endfunction

   // One full sequencer run; poke_at / abort_at name an entry (99 = never).
   task automatic run_seq(input int kk, input logic [255:0] r, input logic tr,
                          input logic [9:0] base, input int poke_at, input int abort_at);
      int  k, n, act_run, mi, mj;
      bit  fin, aborted;
      n = kk * kk; k = 0; act_run = 0; fin = 0; aborted = 0; mi = 0; mj = 0;
      sel = (kk == 2);
      @(negedge clk);
      rho = r; transpose = tr; ram_base = base; start = 1'b1;
      for (int c = 0; c < 4000 && !fin; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (o_rst) begin
            mi = k / kk; mj = k % kk;
            chk("seed", o_m, model_seed(r, tr, mi, mj));
            chk("offset", 272'(o_off), 272'(model_off(base, kk, mi, mj)));
            chk("row", 272'(o_row), 272'(mi));
            chk("col", 272'(o_col), 272'(mj));
            chk("err_clear", 272'(o_err), 272'(0));
            if (k == poke_at) begin
               start = 1'b1;
               rho = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
               ram_base = 10'($urandom);
               transpose = ~tr;
            end
            k++; act_run = 0;
         end
         if (o_act) begin
            act_run++;
            if (act_run == 1) begin
               chk("hold_seed", o_m, model_seed(r, tr, mi, mj));
               chk("hold_offset", 272'(o_off), 272'(model_off(base, kk, mi, mj)));
            end
            if (k - 1 == abort_at && act_run == 2) begin
               rst = 1'b1;
               #1;
               chk("abort_busy", 272'(o_busy), 272'(0));
               chk("abort_active", 272'(o_act), 272'(0));
               chk("abort_genrst", 272'(o_rst), 272'(1));
               chk("abort_rowcol", 272'({o_row, o_col}), 272'(0));
               @(negedge clk);
               rst = 1'b0;
               fin = 1; aborted = 1;
            end
         end
         if (!fin && o_done) begin
            fin = 1;
            chk("done_busy", 272'(o_busy), 272'(1));
            if (stub_stall) begin
               chk("timeout_err", 272'(o_err), 272'(1));
               chk("timeout_entries", 272'(k), 272'(1));
               chk("timeout_waits", 272'(act_run), 272'(TO3 + 1));
               chk("timeout_cycles", 272'(c + 2), 272'(TO3 + 4));
            end else begin
               chk("no_err", 272'(o_err), 272'(0));
               chk("entries", 272'(k), 272'(n));
               chk("done_cycles", 272'(c + 2), 272'(n * (3 + stub_lat) + 2));
            end
         end
      end
      if (!fin) chk("run_bound", 272'(0), 272'(1));
      if (!aborted) begin
         @(negedge clk);
         chk("done_pulse", 272'(o_done), 272'(0));
         chk("idle_busy", 272'(o_busy), 272'(0));
         chk("err_sticky", 272'(o_err), 272'(stub_stall));
      end
      $display("run K=%0d tr=%0d base=%0d lat=%0d stall=%0d entries=%0d aborted=%0d",
               kk, tr, base, stub_lat, stub_stall, k, aborted);
   endtask

   logic [255:0] rho_ramp;

   initial begin
      rst = 1'b1; start = 1'b0; transpose = 1'b0; rho = '0; ram_base = '0;
      sel = 1'b0; stub_lat = 5; stub_stall = 1'b0;
      for (int b = 0; b < 32; b++) rho_ramp[255 - 8*b -: 8] = 8'(b);
      repeat (2) @(negedge clk);
      chk("rst_genrst", 272'(g3_rst), 272'(1));
      chk("rst_outs", 272'({g3_act, g3_busy, g3_done, g3_err, g3_row, g3_col, g3_off}), 272'(0));
      chk("rst_seed", g3_m, 272'(0));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_genrst", 272'(g3_rst), 272'(0));

      run_seq(3, rho_ramp, 1'b0, 10'd0, 99, 99);
      run_seq(3, rho_ramp, 1'b1, 10'd0, 99, 99);
      run_seq(2, rho_ramp, 1'b0, 10'd100, 99, 99);
      run_seq(2, rho_ramp, 1'b1, 10'd1000, 99, 99);

      stub_stall = 1'b1;
      run_seq(3, rho_ramp, 1'b0, 10'd0, 99, 99);
      stub_stall = 1'b0;
      run_seq(3, {8{$urandom}}, 1'b0, 10'($urandom), 99, 99);

      run_seq(3, {8{$urandom}}, 1'b1, 10'($urandom), 4, 99);
      run_seq(3, {8{$urandom}}, 1'b0, 10'($urandom), 99, 5);
      run_seq(3, {8{$urandom}}, 1'b0, 10'($urandom), 99, 99);

      for (int t = 0; t < 8; t++) begin
         stub_lat = int'($urandom_range(1, 8));
         run_seq(($urandom_range(0, 1) == 0) ? 2 : 3,
                 {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                 1'($urandom), 10'($urandom), 99, 99);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
